dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
Shares the single data-memory port between the load unit (reads) and the store unit (writes). Grants one requester per transaction and tracks the outstanding read until its data returns. Generates byte strobes and lane-shifted write data for SB/SH/SW, and flags misaligned stores. Sits between the load/store units and the data memory in the core.

Parameters:
RD_LATENCY, 1, cycles from read issue (mem_en=1, mem_rw_mode=1) to valid mem_rdata; legal 1..3
ADDR_W, 32, address width

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, synchronous, active-high
ld_req  input  1  load request; held until ld_gnt
ld_addr  input  ADDR_W  load word address (byte address, word-aligned access)
ld_gnt  output  1  load granted this cycle (combinational)
ld_rvalid  output  1  one-cycle pulse, ld_rdata valid
ld_rdata  output  32  read data, passthrough of mem_rdata
st_req  input  1  store request; held until st_gnt
st_addr  input  ADDR_W  store byte address
st_data  input  32  store data, right-justified
st_size  input  2  00=SB, 01=SH, 10=SW, 11=illegal
st_gnt  output  1  store granted this cycle (combinational)
st_done  output  1  one-cycle pulse, cycle after st_gnt
st_misalign  output  1  one-cycle pulse with st_done if the store was dropped
mem_en  output  1  memory access enable
mem_rw_mode  output  1  1=read, 0=write; 1 when idle
mem_addr  output  ADDR_W  {addr[ADDR_W-1:2],2'b00} of granted request; 0 when idle
mem_wdata  output  32  lane-shifted store data; 0 unless writing
mem_wstrb  output  4  byte enables; 0 unless writing
mem_rdata  input  32  memory read data

Behaviour:
- Reset (i_rst=1 at posedge): state=IDLE, last_gnt=STORE (so load wins first tie), latency counter=0. All outputs 0 except mem_rw_mode=1.
- FSM states: IDLE, RD_WAIT.
- IDLE: only ld_req -> ld_gnt=1. Only st_req -> st_gnt=1. Both -> grant the requester not in last_gnt (round-robin), then update last_gnt. None -> no grant.
- Load grant: mem_en=1, mem_rw_mode=1, mem_addr driven the same cycle. Next state is RD_WAIT with counter=RD_LATENCY-1.
- RD_WAIT: no grants; all mem_* outputs idle. Counter decrements each cycle. ld_rvalid=1 in the cycle exactly RD_LATENCY cycles after the grant, i.e. the cycle counter==0 in RD_WAIT. Return to IDLE the following cycle.
- Read-to-read throughput: one load per RD_LATENCY+1 cycles.
- Store grant: mem_en=1, mem_rw_mode=0 the same cycle. Stay in IDLE; back-to-back store grants are legal. st_done pulses the next cycle.
- Lanes, with off=st_addr[1:0]:
  - SB: wstrb=4'b0001<<off; wdata=st_data[7:0] replicated on all 4 lanes.
  - SH: wstrb=4'b0011<<off; wdata={2{st_data[15:0]}}.
  - SW: wstrb=4'b1111; wdata=st_data.
- Misaligned (SH with off[0]=1, SW with off!=0) or st_size=11:
  - Still granted, but mem_en=0 and wstrb=0 (no write).
  - st_done and st_misalign both pulse the next cycle.
- Requests arriving during RD_WAIT wait; the fairness pointer is not touched until a grant.
- ld_gnt and st_gnt are never both 1.
- ld_rdata is 0 whenever ld_rvalid=0.
- Reset mid-RD_WAIT: abort to IDLE and drop the pending ld_rvalid.

Decomposition:
- Shared defines file (processor_defines.sv): st_size encodings (ST_SB/ST_SH/ST_SW), FSM state encodings, requester IDs for last_gnt.
- One combinational sub-module store_lane_align: inputs st_size and addr[1:0], outputs wstrb, wdata, misalign.
- FSM, counter and fairness pointer stay in dmem_port_arbiter.

Test Plan:
- Load only, RD_LATENCY=1, ld_addr=0x104, mem_rdata=0xDEADBEEF -> ld_gnt at T, mem_addr=0x104, mem_rw_mode=1; ld_rvalid=1 and ld_rdata=0xDEADBEEF at T+1; no grant at T+1.
- SB at st_addr=0x203, st_data=0x000000A5 -> st_gnt at T, mem_addr=0x200, wstrb=4'b1000, wdata=0xA5A5A5A5, mem_rw_mode=0; st_done at T+1, st_misalign=0.
- SW at st_addr=0x102 -> st_gnt at T, mem_en=0, wstrb=0; st_done=1 and st_misalign=1 at T+1.
- ld_req and st_req held high together after reset -> grants alternate load (T), RD_WAIT (T+1), store (T+2), load (T+3); the two gnts are never coincident.
- RD_LATENCY=3, load granted at T, i_rst=1 at T+1 -> all outputs at reset values from T+2; no ld_rvalid at T+3.
- Four back-to-back SH at 0x10/0x12/0x14/0x16 -> st_gnt every cycle, wstrb 0011/1100/0011/1100, four st_done pulses T+1..T+4.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: store sizes, FSM states,
// requester IDs and the base byte-enable pattern for each store size.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_SB  = 2'b00,
    ST_SH  = 2'b01,
    ST_SW  = 2'b10,
    ST_ILL = 2'b11
  } st_size_e;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_RD_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic {
    REQ_LOAD  = 1'b0,
    REQ_STORE = 1'b1
  } req_id_e;

  localparam int unsigned CNT_W = 2;

  // Byte-enable pattern for lane 0; the aligner shifts it by the byte offset.
  function automatic logic [3:0] size_mask(input st_size_e sz);
    logic [3:0] m;
    case (sz)
      ST_SB:   m = 4'b0001;
      ST_SH:   m = 4'b0011;
      ST_SW:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Load/store-unit and data-memory signals of the arbiter, bundled as one
// interface. slave = arbiter side, master = requesters plus memory model.
interface dmem_port_arbiter_if #(parameter int ADDR_W = 32);
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [31:0]       ld_rdata;

  logic              st_req;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic [1:0]        st_size;
  logic              st_gnt;
  logic              st_done;
  logic              st_misalign;

  logic              mem_en;
  logic              mem_rw_mode;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_rdata;

  modport slave (
    input  ld_req, ld_addr, st_req, st_addr, st_data, st_size, mem_rdata,
    output ld_gnt, ld_rvalid, ld_rdata, st_gnt, st_done, st_misalign,
           mem_en, mem_rw_mode, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output ld_req, ld_addr, st_req, st_addr, st_data, st_size, mem_rdata,
    input  ld_gnt, ld_rvalid, ld_rdata, st_gnt, st_done, st_misalign,
           mem_en, mem_rw_mode, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/dmem_port_arbiter_store_lane_align.sv
// Combinational store lane steering: byte strobes and replicated write data
// for SB/SH/SW, with a misalign flag that suppresses the write.
module dmem_port_arbiter_store_lane_align
  import dmem_port_arbiter_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o
);

  st_size_e sz;
  assign sz = st_size_e'(st_size_i);

  always_comb begin
    wstrb_o    = 4'b0000;
    wdata_o    = 32'h0;
    misalign_o = 1'b0;
    case (sz)
      ST_SB: begin
        wstrb_o = size_mask(sz) << off_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      ST_SH: begin
        if (off_i[0]) begin
          misalign_o = 1'b1;
        end else begin
          wstrb_o = size_mask(sz) << off_i;
          wdata_o = {2{st_data_i[15:0]}};
        end
      end
      ST_SW: begin
        if (off_i != 2'b00) begin
          misalign_o = 1'b1;
        end else begin
          wstrb_o = size_mask(sz);
          wdata_o = st_data_i;
        end
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between the load and store units: round-robin
// grant, read-latency tracking and store lane alignment.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | port free; grant a load or store this cycle
//   S_RD_WAIT | load outstanding; counter runs down to the data-return cycle
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 32
) (
  input logic                i_clk,
  input logic                i_rst,
  dmem_port_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(RD_LATENCY - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));

  arb_state_e       state_q, state_d;
  req_id_e          last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             st_done_q, st_mis_q;

  logic        ld_gnt, st_gnt, rd_done;
  logic [3:0]  al_strb;
  logic [31:0] al_wdata;
  logic        al_mis;

  dmem_port_arbiter_store_lane_align u_align (
    .st_size_i  (bus.st_size),
    .off_i      (bus.st_addr[1:0]),
    .st_data_i  (bus.st_data),
    .wstrb_o    (al_strb),
    .wdata_o    (al_wdata),
    .misalign_o (al_mis)
  );

  // Grants are gated by reset so the port looks idle during the reset cycle.
  always_comb begin
    ld_gnt = 1'b0;
    st_gnt = 1'b0;
    if (!i_rst && state_q == S_IDLE) begin
      if (bus.ld_req && bus.st_req) begin
        if (last_gnt_q == REQ_STORE) ld_gnt = 1'b1;
        else                         st_gnt = 1'b1;
      end else begin
        ld_gnt = bus.ld_req;
        st_gnt = bus.st_req;
      end
    end
  end

  assign rd_done = !i_rst && (state_q == S_RD_WAIT) && (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      S_IDLE: begin
        if (ld_gnt) begin
          state_d    = S_RD_WAIT;
          cnt_d      = CNT_INIT;
          last_gnt_d = REQ_LOAD;
        end else if (st_gnt) begin
          last_gnt_d = REQ_STORE;
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      last_gnt_q <= REQ_STORE;
      cnt_q      <= '0;
      st_done_q  <= 1'b0;
      st_mis_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      st_done_q  <= st_gnt;
      st_mis_q   <= st_gnt & al_mis;
    end
  end

  assign bus.ld_gnt      = ld_gnt;
  assign bus.st_gnt      = st_gnt;
  assign bus.ld_rvalid   = rd_done;
  assign bus.ld_rdata    = rd_done ? bus.mem_rdata : 32'h0;
  assign bus.st_done     = st_done_q;
  assign bus.st_misalign = st_mis_q;

  assign bus.mem_en      = ld_gnt | (st_gnt & ~al_mis);
  assign bus.mem_rw_mode = ~st_gnt;
  assign bus.mem_addr    = ld_gnt ? (bus.ld_addr & WORD_MASK) :
                           st_gnt ? (bus.st_addr & WORD_MASK) : '0;
  assign bus.mem_wstrb   = st_gnt ? al_strb  : 4'b0000;
  assign bus.mem_wdata   = st_gnt ? al_wdata : 32'h0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter at RD_LATENCY 1, 2 and 3: directed
// scenarios followed by random traffic and random resets.
module tb_dmem_port_arbiter;

  int checks = 0;
  int errors = 0;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam int NCYC       = 1500;
  localparam int RAND_START = 70;
  localparam int DRAIN      = 20;

  typedef struct {
    int          cyc;
    bit          is_ld;
    logic [31:0] addr;
    bit          en;
    logic [3:0]  strb;
    logic [31:0] wdata;
    bit          mis;
  } gnt_rec_t;
  typedef struct { int cyc; logic [31:0] data; } rv_rec_t;
  typedef struct { int cyc; bit mis; } dn_rec_t;
  typedef struct { int rel; logic [31:0] addr; bit rst_after; } ld_job_t;
  typedef struct { int rel; logic [31:0] addr; logic [31:0] data; logic [1:0] size; } st_job_t;

  task automatic chk(input string name, input int lat, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (lat %0d) at %0t: got %h expected %h", name, lat, $time, act, exp);
    end
  endtask

  // Store effect from the size/offset rules: nb bytes starting at off,
  // each lane carrying byte (lane mod nb) of the right-justified data.
  function automatic void exp_store(input logic [1:0] size, input logic [1:0] off, input logic [31:0] d,
                                    output bit mis, output logic [3:0] strb, output logic [31:0] wd);
    int nb = 1 << size;
    int o  = int'(off);
    mis  = (size == 2'd3) || ((o % nb) != 0);
    strb = 4'b0000;
    wd   = 32'h0;
    if (!mis) begin
      for (int i = 0; i < 4; i++) begin
        strb[i]     = (i >= o) && (i < o + nb);
        wd[8*i +: 8] = d[8*(i % nb) +: 8];
      end
    end
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lat
      localparam int LAT = gi + 1;

      logic rst;
      dmem_port_arbiter_if #(.ADDR_W(32)) bus ();
      dmem_port_arbiter #(.RD_LATENCY(LAT), .ADDR_W(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
      );

      gnt_rec_t gnt_q[$];
      rv_rec_t  rv_q[$];
      dn_rec_t  dn_q[$];
      ld_job_t  ld_jobs[$];
      st_job_t  st_jobs[$];
      int cyc     = -1;
      bit running = 1'b0;
      bit done    = 1'b0;

      function automatic logic [31:0] rdata_of(input int n);
        return (32'(n) * 32'h9E3779B1) ^ (32'h5A5A_0000 + 32'(LAT));
      endfunction

      initial begin : drive
        bit ld_v, st_v, ld_rst_flag, rst_next, rst_now, take_ld, mis;
        logic [31:0] ld_a, st_a, st_d, wd;
        logic [1:0]  st_s;
        logic [3:0]  strb;
        int free_at;
        bit last_st;
        gnt_rec_t g;
        ld_job_t lj;
        st_job_t sj;

        ld_jobs.push_back('{rel: 4,  addr: 32'h104, rst_after: 1'b0});
        ld_jobs.push_back('{rel: 20, addr: 32'h300, rst_after: 1'b0});
        ld_jobs.push_back('{rel: 20, addr: 32'h308, rst_after: 1'b0});
        ld_jobs.push_back('{rel: 50, addr: 32'h400, rst_after: 1'b1});
        st_jobs.push_back('{rel: 10, addr: 32'h203, data: 32'h0000_00A5, size: 2'd0});
        st_jobs.push_back('{rel: 12, addr: 32'h102, data: 32'h1122_3344, size: 2'd2});
        st_jobs.push_back('{rel: 20, addr: 32'h304, data: 32'hCAFE_F00D, size: 2'd2});
        st_jobs.push_back('{rel: 40, addr: 32'h010, data: 32'h0000_1111, size: 2'd1});
        st_jobs.push_back('{rel: 40, addr: 32'h012, data: 32'h0000_2222, size: 2'd1});
        st_jobs.push_back('{rel: 40, addr: 32'h014, data: 32'h0000_3333, size: 2'd1});
        st_jobs.push_back('{rel: 40, addr: 32'h016, data: 32'h0000_4444, size: 2'd1});
        st_jobs.push_back('{rel: 60, addr: 32'h020, data: 32'h0000_0055, size: 2'd3});

        rst = 1'b1;
        bus.ld_req = 1'b0; bus.ld_addr = '0;
        bus.st_req = 1'b0; bus.st_addr = '0; bus.st_data = '0; bus.st_size = '0;
        bus.mem_rdata = '0;
        ld_v = 0; st_v = 0; ld_rst_flag = 0; rst_next = 0;
        ld_a = 0; st_a = 0; st_d = 0; st_s = 0;
        free_at = 0; last_st = 1'b1;
        running = 1'b1;

        for (int n = 0; n < NCYC; n++) begin
          @(posedge clk); #1;
          cyc = n;
          rst_now = (n < 3) || rst_next ||
                    (n >= RAND_START && n < NCYC - DRAIN && $urandom_range(0, 79) == 0);
          rst_next = 1'b0;

          if (!ld_v) begin
            if (ld_jobs.size() > 0) begin
              if (ld_jobs[0].rel <= n) begin
                lj = ld_jobs.pop_front();
                ld_v = 1'b1; ld_a = lj.addr; ld_rst_flag = lj.rst_after;
              end
            end else if (n >= RAND_START && n < NCYC - DRAIN && $urandom_range(0, 2) == 0) begin
              ld_v = 1'b1; ld_a = $urandom() & 32'hFFFF_FFFC; ld_rst_flag = 1'b0;
            end
          end
          if (!st_v) begin
            if (st_jobs.size() > 0) begin
              if (st_jobs[0].rel <= n) begin
                sj = st_jobs.pop_front();
                st_v = 1'b1; st_a = sj.addr; st_d = sj.data; st_s = sj.size;
              end
            end else if (n >= RAND_START && n < NCYC - DRAIN && $urandom_range(0, 1) == 0) begin
              st_v = 1'b1; st_a = $urandom(); st_d = $urandom(); st_s = 2'($urandom_range(0, 3));
            end
          end

          rst = rst_now;
          bus.ld_req = ld_v; bus.ld_addr = ld_a;
          bus.st_req = st_v; bus.st_addr = st_a; bus.st_data = st_d; bus.st_size = st_s;
          bus.mem_rdata = rdata_of(n);

          // Reference: the port is free from cycle free_at; ties go to whoever
          // was not granted last.
          if (rst_now) begin
            free_at = n + 1;
            last_st = 1'b1;
            while (rv_q.size() > 0 && rv_q[rv_q.size()-1].cyc >= n) void'(rv_q.pop_back());
            while (dn_q.size() > 0 && dn_q[dn_q.size()-1].cyc > n) void'(dn_q.pop_back());
          end else if (n >= free_at && (ld_v || st_v)) begin
            take_ld = ld_v && (!st_v || last_st);
            g.cyc = n;
            if (take_ld) begin
              g.is_ld = 1'b1; g.addr = ld_a & 32'hFFFF_FFFC; g.en = 1'b1;
              g.strb = 4'b0000; g.wdata = 32'h0; g.mis = 1'b0;
              gnt_q.push_back(g);
              rv_q.push_back('{cyc: n + LAT, data: rdata_of(n + LAT)});
              free_at = n + LAT + 1;
              last_st = 1'b0;
              ld_v = 1'b0;
              if (ld_rst_flag) rst_next = 1'b1;
            end else begin
              exp_store(st_s, st_a[1:0], st_d, mis, strb, wd);
              g.is_ld = 1'b0; g.addr = st_a & 32'hFFFF_FFFC; g.en = !mis;
              g.strb = strb; g.wdata = wd; g.mis = mis;
              gnt_q.push_back(g);
              dn_q.push_back('{cyc: n + 1, mis: mis});
              free_at = n + 1;
              last_st = 1'b1;
              st_v = 1'b0;
            end
          end
        end
        @(posedge clk); #1;
        running = 1'b0;
        chk("leftover_expectations", LAT, 32'(gnt_q.size() + rv_q.size() + dn_q.size()), 32'd0);
        done = 1'b1;
      end

      always @(negedge clk) begin : mon
        gnt_rec_t g;
        rv_rec_t  r;
        dn_rec_t  d;
        if (running && cyc >= 1) begin
          while (gnt_q.size() > 0 && gnt_q[0].cyc < cyc) begin
            chk("grant_missing", LAT, 32'(cyc), 32'(gnt_q[0].cyc));
            void'(gnt_q.pop_front());
          end
          while (rv_q.size() > 0 && rv_q[0].cyc < cyc) begin
            chk("rvalid_missing", LAT, 32'(cyc), 32'(rv_q[0].cyc));
            void'(rv_q.pop_front());
          end
          while (dn_q.size() > 0 && dn_q[0].cyc < cyc) begin
            chk("st_done_missing", LAT, 32'(cyc), 32'(dn_q[0].cyc));
            void'(dn_q.pop_front());
          end

          chk("gnt_exclusive", LAT, {31'b0, bus.ld_gnt & bus.st_gnt}, 32'd0);
          if (bus.ld_gnt === 1'b1 || bus.st_gnt === 1'b1) begin
            if (gnt_q.size() == 0) begin
              chk("unexpected_grant", LAT, {30'b0, bus.ld_gnt, bus.st_gnt}, 32'd0);
            end else begin
              g = gnt_q.pop_front();
              chk("grant_cycle",  LAT, 32'(cyc), 32'(g.cyc));
              chk("ld_gnt",       LAT, {31'b0, bus.ld_gnt}, {31'b0, g.is_ld});
              chk("st_gnt",       LAT, {31'b0, bus.st_gnt}, {31'b0, !g.is_ld});
              chk("mem_en",       LAT, {31'b0, bus.mem_en}, {31'b0, g.en});
              chk("mem_wstrb",    LAT, {28'b0, bus.mem_wstrb}, {28'b0, g.strb});
              chk("mem_wdata",    LAT, bus.mem_wdata, g.wdata);
              if (g.is_ld || !g.mis) begin
                chk("mem_addr",    LAT, bus.mem_addr, g.addr);
                chk("mem_rw_mode", LAT, {31'b0, bus.mem_rw_mode}, {31'b0, g.is_ld});
              end
            end
          end else begin
            chk("idle_mem_en",      LAT, {31'b0, bus.mem_en}, 32'd0);
            chk("idle_mem_rw_mode", LAT, {31'b0, bus.mem_rw_mode}, 32'd1);
            chk("idle_mem_addr",    LAT, bus.mem_addr, 32'd0);
            chk("idle_mem_wstrb",   LAT, {28'b0, bus.mem_wstrb}, 32'd0);
            chk("idle_mem_wdata",   LAT, bus.mem_wdata, 32'd0);
          end

          if (bus.ld_rvalid === 1'b1) begin
            if (rv_q.size() == 0) begin
              chk("unexpected_rvalid", LAT, 32'd1, 32'd0);
            end else begin
              r = rv_q.pop_front();
              chk("rvalid_cycle", LAT, 32'(cyc), 32'(r.cyc));
              chk("ld_rdata",     LAT, bus.ld_rdata, r.data);
            end
          end else begin
            chk("rdata_zero_when_invalid", LAT, bus.ld_rdata, 32'd0);
          end

          if (bus.st_done === 1'b1) begin
            if (dn_q.size() == 0) begin
              chk("unexpected_st_done", LAT, 32'd1, 32'd0);
            end else begin
              d = dn_q.pop_front();
              chk("st_done_cycle", LAT, 32'(cyc), 32'(d.cyc));
              chk("st_misalign",   LAT, {31'b0, bus.st_misalign}, {31'b0, d.mis});
            end
          end else begin
            chk("misalign_without_done", LAT, {31'b0, bus.st_misalign}, 32'd0);
          end
        end
      end
    end
  endgenerate

  initial begin : top_ctl
    bit all_done;
    all_done = 1'b0;
    for (int t = 0; t < 5000 && !all_done; t++) begin
      @(posedge clk);
      all_done = g_lat[0].done && g_lat[1].done && g_lat[2].done;
    end
    if (!all_done) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: drivers did not complete");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
